// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage of a RISC-V style core.
//
// Sits between the EX/MEM and MEM/WB pipeline registers. Non-memory
// instructions pass straight through to MEM/WB in one cycle. Aligned loads
// and stores are latched and issued on a simple req/ack data bus while the
// upstream pipeline is stalled. Misaligned accesses are squashed and flagged.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   valid_in                 EX/MEM slot holds a live instruction
//   alu_result_in            ALU result / byte address of the access
//   rd2_in                   store data
//   rd_in                    destination register
//   funct3_in                access size/sign (B, H, W, BU, HU; others = W)
//   RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in   EX/MEM control
//   dmem_req/we/addr/wdata/be  data bus request (addr word aligned)
//   dmem_rdata, dmem_ack     data bus response (ack is a one-cycle strobe)
//   stall                    combinational; upstream holds EX/MEM while 1
//   misaligned_exc           one-cycle pulse on a misaligned access
//   wb_*                     registered MEM/WB outputs
// ---------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rd2_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemToReg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        misaligned_exc,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic        wb_MemToReg,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_mem_data,
  output logic [4:0]  wb_rd
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state_reg, state_next;

  // Access latched at issue; drives the bus for the whole ACCESS phase.
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [4:0]  rd_reg;
  logic        regwrite_reg;
  logic        memtoreg_reg;

  // Incoming instruction decode
  logic        mem_op;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic [31:0] store_wdata;
  logic [3:0]  store_be;

  // Load formatting
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;

  // Control from the FSM process
  logic        latch_en;
  logic        wb_valid_next;
  logic        wb_regwrite_next;
  logic        wb_memtoreg_next;
  logic [31:0] wb_alu_result_next;
  logic [31:0] wb_mem_data_next;
  logic [4:0]  wb_rd_next;

  assign mem_op  = valid_in & (MemRead_in | MemWrite_in);
  // funct3[2] is only the unsigned flag, so size comes from funct3[1:0];
  // anything that is neither byte nor half is handled as a word.
  assign is_byte = (funct3_in[1:0] == 2'b00);
  assign is_half = (funct3_in[1:0] == 2'b01);
  assign misaligned = is_half ? alu_result_in[0]
                    : is_byte ? 1'b0
                    : (alu_result_in[1:0] != 2'b00);

  // Store data is replicated across lanes so the bus only needs the byte
  // enables to pick the right bytes. Loads always read the full word.
  always_comb begin
    store_wdata = rd2_in;
    store_be    = 4'b1111;
    if (MemWrite_in) begin
      if (is_byte) begin
        store_wdata = {4{rd2_in[7:0]}};
        store_be    = 4'b0001 << alu_result_in[1:0];
      end else if (is_half) begin
        store_wdata = {2{rd2_in[15:0]}};
        store_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  // Bring the addressed lane down to bit 0; halfwords are aligned, so a
  // byte-granular shift selects them correctly as well.
  assign rdata_shifted = dmem_rdata >> {addr_reg[1:0], 3'b000};

  always_comb begin
    case (funct3_reg)
      3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
      3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  // Bus outputs are qualified by state so IDLE never presents a request.
  assign dmem_req   = (state_reg == ACCESS);
  assign dmem_we    = (state_reg == ACCESS) & we_reg;
  assign dmem_be    = (state_reg == ACCESS) ? be_reg : 4'b0000;
  assign dmem_addr  = {addr_reg[31:2], 2'b00};
  assign dmem_wdata = wdata_reg;

  // Next-state and MEM/WB selection. Default is a bubble into MEM/WB.
  always_comb begin
    state_next         = state_reg;
    stall              = 1'b0;
    misaligned_exc     = 1'b0;
    latch_en           = 1'b0;
    wb_valid_next      = 1'b0;
    wb_regwrite_next   = 1'b0;
    wb_memtoreg_next   = 1'b0;
    wb_alu_result_next = 32'd0;
    wb_mem_data_next   = 32'd0;
    wb_rd_next         = 5'd0;
    case (state_reg)
      IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            misaligned_exc = 1'b1;
          end else begin
            stall      = 1'b1;
            latch_en   = 1'b1;
            state_next = ACCESS;
          end
        end else begin
          wb_valid_next      = valid_in;
          wb_regwrite_next   = valid_in & RegWrite_in;
          wb_memtoreg_next   = MemToReg_in;
          wb_alu_result_next = alu_result_in;
          wb_rd_next         = rd_in;
        end
      end
      ACCESS: begin
        stall = ~dmem_ack;
        if (dmem_ack) begin
          state_next         = IDLE;
          wb_valid_next      = 1'b1;
          wb_regwrite_next   = regwrite_reg & ~we_reg;
          wb_memtoreg_next   = memtoreg_reg;
          wb_alu_result_next = addr_reg;
          wb_mem_data_next   = we_reg ? 32'd0 : load_data;
          wb_rd_next         = rd_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      be_reg       <= 4'd0;
      we_reg       <= 1'b0;
      funct3_reg   <= 3'd0;
      rd_reg       <= 5'd0;
      regwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
    end else if (latch_en) begin
      addr_reg     <= alu_result_in;
      wdata_reg    <= store_wdata;
      be_reg       <= store_be;
      we_reg       <= MemWrite_in;
      funct3_reg   <= funct3_in;
      rd_reg       <= rd_in;
      regwrite_reg <= RegWrite_in;
      memtoreg_reg <= MemToReg_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_RegWrite   <= 1'b0;
      wb_MemToReg   <= 1'b0;
      wb_alu_result <= 32'd0;
      wb_mem_data   <= 32'd0;
      wb_rd         <= 5'd0;
    end else begin
      wb_valid      <= wb_valid_next;
      wb_RegWrite   <= wb_regwrite_next;
      wb_MemToReg   <= wb_memtoreg_next;
      wb_alu_result <= wb_alu_result_next;
      wb_mem_data   <= wb_mem_data_next;
      wb_rd         <= wb_rd_next;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- directed bench for mem_stage.
// Stimulus pushes the expected MEM/WB record into a queue; a monitor on the
// falling edge pops and compares whenever wb_valid is presented. Bus-side and
// stall behaviour is checked inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_result_in;
  logic [31:0] rd2_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall, misaligned_exc;
  logic        wb_valid, wb_RegWrite, wb_MemToReg;
  logic [31:0] wb_alu_result, wb_mem_data;
  logic [4:0]  wb_rd;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mdata;
    logic        regwrite;
    logic        memtoreg;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result_in(alu_result_in),
    .rd2_in(rd2_in), .rd_in(rd_in), .funct3_in(funct3_in),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall(stall), .misaligned_exc(misaligned_exc),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    valid_in      = 1'b0;
    alu_result_in = 32'd0;
    rd2_in        = 32'd0;
    rd_in         = 5'd0;
    funct3_in     = 3'd0;
    RegWrite_in   = 1'b0;
    MemRead_in    = 1'b0;
    MemWrite_in   = 1'b0;
    MemToReg_in   = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    wb_exp_t e;
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb actual=rd%0d alu=0x%08h required=no_writeback", wb_rd, wb_alu_result);
      end else begin
        e = exp_q.pop_front();
        $display("wb rd=%0d alu=0x%08h mem=0x%08h rw=%0b m2r=%0b", wb_rd, wb_alu_result, wb_mem_data, wb_RegWrite, wb_MemToReg);
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_alu_result", wb_alu_result, e.alu);
        check("wb_mem_data", wb_mem_data, e.mdata);
        check("wb_RegWrite", 32'(wb_RegWrite), 32'(e.regwrite));
        check("wb_MemToReg", 32'(wb_MemToReg), 32'(e.memtoreg));
      end
    end
  end

  // One aligned load/store, ack arriving ack_dly cycles after req rises.
  task automatic mem_access(input string nm, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [2:0] f3,
                            input logic store, input logic [4:0] rd,
                            input logic [31:0] rdata, input int ack_dly,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_mdata);
    int stall_cnt;
    wb_exp_t e;
    @(posedge clk); #1;
    valid_in      = 1'b1;
    alu_result_in = addr;
    rd2_in        = sdata;
    rd_in         = rd;
    funct3_in     = f3;
    MemRead_in    = ~store;
    MemWrite_in   = store;
    RegWrite_in   = ~store;
    MemToReg_in   = ~store;
    e.rd = rd; e.alu = addr; e.mdata = exp_mdata; e.regwrite = ~store; e.memtoreg = ~store;
    exp_q.push_back(e);
    $display("txn %s addr=0x%08h sdata=0x%08h rdata=0x%08h ack_dly=%0d", nm, addr, sdata, rdata, ack_dly);
    stall_cnt = 0;
    @(negedge clk);
    check({nm, "_issue_stall"}, 32'(stall), 32'd1);
    check({nm, "_idle_req"}, 32'(dmem_req), 32'd0);
    stall_cnt += int'(stall);
    for (int k = 1; k <= ack_dly; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k == 1) begin
        check({nm, "_req"}, 32'(dmem_req), 32'd1);
        check({nm, "_we"}, 32'(dmem_we), 32'(store));
        check({nm, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        check({nm, "_be"}, 32'(dmem_be), 32'(exp_be));
        if (store) check({nm, "_wdata"}, dmem_wdata, exp_wdata);
      end
      stall_cnt += int'(stall);
    end
    @(posedge clk); #1;
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    @(negedge clk);
    check({nm, "_ack_stall"}, 32'(stall), 32'd0);
    check({nm, "_ack_req"}, 32'(dmem_req), 32'd1);
    stall_cnt += int'(stall);
    @(posedge clk); #1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    idle_inputs();
    check({nm, "_stall_cycles"}, 32'(stall_cnt), 32'(ack_dly + 1));
    @(negedge clk);
    check({nm, "_done_req"}, 32'(dmem_req), 32'd0);
    check({nm, "_done_be"}, 32'(dmem_be), 32'd0);
  endtask

  initial begin : stimulus
    wb_exp_t e;
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    idle_inputs();
    @(negedge clk);
    check("reset_wb_valid", 32'(wb_valid), 32'd0);
    check("reset_wb_alu", wb_alu_result, 32'd0);
    check("reset_req", 32'(dmem_req), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU pass-through
    @(posedge clk); #1;
    valid_in = 1'b1; rd_in = 5'd5; alu_result_in = 32'h0000_1234; RegWrite_in = 1'b1;
    e.rd = 5'd5; e.alu = 32'h0000_1234; e.mdata = 32'd0; e.regwrite = 1'b1; e.memtoreg = 1'b0;
    exp_q.push_back(e);
    $display("txn alu rd=5 result=0x00001234");
    @(negedge clk);
    check("alu_stall", 32'(stall), 32'd0);
    check("alu_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("alu_stall_after", 32'(stall), 32'd0);

    mem_access("lb",  32'h0000_0103, 32'd0,          3'b000, 1'b0, 5'd7,  32'h80FF_FF00, 3, 4'b1111, 32'd0,          32'hFFFF_FF80);
    mem_access("sh",  32'h0000_0202, 32'h0000_ABCD,  3'b001, 1'b1, 5'd8,  32'd0,         1, 4'b1100, 32'hABCD_ABCD,  32'd0);
    mem_access("lhu", 32'h0000_0002, 32'd0,          3'b101, 1'b0, 5'd10, 32'h8001_0000, 2, 4'b1111, 32'd0,          32'h0000_8001);
    mem_access("sb",  32'h0000_0301, 32'h1234_565A,  3'b000, 1'b1, 5'd11, 32'd0,         1, 4'b0010, 32'h5A5A_5A5A,  32'd0);
    mem_access("lh",  32'h0000_0004, 32'd0,          3'b001, 1'b0, 5'd12, 32'h1234_F00D, 1, 4'b1111, 32'd0,          32'hFFFF_F00D);
    mem_access("lw",  32'h0000_0400, 32'd0,          3'b010, 1'b0, 5'd13, 32'hDEAD_BEEF, 2, 4'b1111, 32'd0,          32'hDEAD_BEEF);

    // Misaligned LW
    @(posedge clk); #1;
    valid_in = 1'b1; alu_result_in = 32'h0000_0101; funct3_in = 3'b010;
    MemRead_in = 1'b1; RegWrite_in = 1'b1; MemToReg_in = 1'b1; rd_in = 5'd3;
    $display("txn lw_misaligned addr=0x00000101");
    @(negedge clk);
    check("mis_exc", 32'(misaligned_exc), 32'd1);
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("mis_exc_pulse", 32'(misaligned_exc), 32'd0);
    check("mis_wb_valid", 32'(wb_valid), 32'd0);
    check("mis_req_after", 32'(dmem_req), 32'd0);

    // Reset during ACCESS, then a late ack
    @(posedge clk); #1;
    valid_in = 1'b1; alu_result_in = 32'h0000_0200; funct3_in = 3'b010;
    MemRead_in = 1'b1; RegWrite_in = 1'b1; MemToReg_in = 1'b1; rd_in = 5'd9;
    $display("txn lw_reset_abort addr=0x00000200");
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_req_before", 32'(dmem_req), 32'd1);
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    check("abort_req_async", 32'(dmem_req), 32'd0);
    check("abort_be_async", 32'(dmem_be), 32'd0);
    check("abort_wb_valid", 32'(wb_valid), 32'd0);
    check("abort_wb_rd", 32'(wb_rd), 32'd0);
    check("abort_wb_mem", wb_mem_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check("late_ack_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    @(negedge clk);
    check("late_ack_wb_valid", 32'(wb_valid), 32'd0);
    check("late_ack_wb_mem", wb_mem_data, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 valid_in  in  1  EX/MEM slot holds a live instruction.
REQ-004 alu_result_in  in  32  ALU result; byte address for loads/stores.
REQ-005 rd2_in  in  32  store data.
REQ-006 rd_in  in  5  destination register.
REQ-007 funct3_in  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W.
REQ-008 RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in  in  1 each  control from EX/MEM.
REQ-009 dmem_req  out  1  bus request, held until acknowledged.
REQ-010 dmem_we  out  1  1 = write.
REQ-011 dmem_addr  out  32  word address, bits [1:0] = 0.
REQ-012 dmem_wdata  out  32  lane-aligned store data.
REQ-013 dmem_be  out  4  byte enables; bit i = byte lane i.
REQ-014 dmem_rdata  in  32  read data, valid when dmem_ack = 1.
REQ-015 dmem_ack  in  1  one-cycle completion strobe.
REQ-016 stall  out  1  combinational; upstream holds EX/MEM while 1.
REQ-017 misaligned_exc  out  1  one-cycle pulse on misaligned access.
REQ-018 wb_valid, wb_RegWrite, wb_MemToReg  out  1 each  registered MEM/WB control.
REQ-019 wb_alu_result, wb_mem_data  out  32 each  registered MEM/WB data.
REQ-020 wb_rd  out  5  registered MEM/WB destination register.

Function
REQ-021 Memory op = valid_in & (MemRead_in | MemWrite_in); MemWrite_in = 1 means store, overriding MemRead_in.
REQ-022 Misaligned = H/HU with addr[0] = 1, or W with addr[1:0] != 0.
REQ-023 Two-state FSM, IDLE and ACCESS; reset state IDLE.
REQ-024 IDLE, non-memory op: MEM/WB captures inputs at next edge; wb_mem_data = 0; stall = 0; latency 1 cycle.
REQ-025 IDLE, aligned memory op: stall = 1; latch address, data, size, rd and control; MEM/WB captures a bubble (wb_valid = 0, wb_RegWrite = 0); go to ACCESS.
REQ-026 IDLE, misaligned op: no bus request; misaligned_exc = 1 for that cycle; MEM/WB captures a bubble; stall = 0.
REQ-027 ACCESS: dmem_req = 1 with dmem_we/addr/wdata/be stable from latched values; stall = !dmem_ack.
REQ-028 ACCESS with dmem_ack = 1: MEM/WB captures the latched instruction (wb_valid = 1) with formatted read data; return to IDLE at the same edge.
REQ-029 dmem_ack while in IDLE is ignored.
REQ-030 Store lanes: SB replicates byte to all lanes, be = 0001 << addr[1:0]; SH replicates halfword, be = 0011 << (2*addr[1]); SW be = 1111.
REQ-031 Load format: select lane by latched addr[1:0]; B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-032 Stores complete with wb_RegWrite forced to 0.
REQ-033 dmem_req, dmem_we, dmem_be are 0 in IDLE.

Reset
REQ-034 rst = 1 forces state IDLE and zeroes every registered output immediately, including mid-ACCESS; dmem_req drops asynchronously.
REQ-035 A dmem_ack arriving after reset is ignored; the aborted access is not replayed.

Verification
REQ-036 ALU op, rd = 5, result 0x1234 -> next edge wb_valid = 1, wb_rd = 5, wb_alu_result = 0x1234, stall never 1.
REQ-037 LB at 0x103, rdata 0x80FF_FF00, ack 3 cycles after req -> dmem_addr = 0x100, be = 1111 (read), stall high 4 cycles, wb_mem_data = 0xFFFF_FF80.
REQ-038 SH at 0x202, data 0x0000_ABCD -> dmem_addr = 0x200, be = 1100, wdata = 0xABCD_ABCD, we = 1, wb_RegWrite = 0.
REQ-039 LW at 0x101 -> misaligned_exc pulses once, dmem_req stays 0, wb_valid = 0, stall = 0.
REQ-040 rst asserted during ACCESS, then ack pulsed -> dmem_req = 0 immediately, all wb_* = 0, late ack causes no MEM/WB update.
REQ-041 LHU at 0x002, rdata 0x8001_0000 -> wb_mem_data = 0x0000_8001.
